mem_bus_arbiter: RTL and testbench

Shares a single external memory bus between the instruction-fetch port and the MEM-stage data port. Each request becomes one bus transaction under a req/ack handshake. The block raises per-port stall requests toward the pipeline controller until the data is returned. The returned word is held until the pipeline actually advances past the stalled stage. It sits between the IF/MEM stage logic and the SoC bus, alongside the stall/flush controller that drives the pipeline latches.

---
 rtl/mem_bus_arbiter_pkg.sv | 23 ++
 rtl/mem_bus_arbiter_arb_watchdog.sv | 36 +++
 rtl/mem_bus_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: FSM state encodings,
// pipeline stall-vector bit positions and the fetch byte-lane mask.
package mem_bus_arbiter_pkg;

   typedef enum logic [2:0] {
      ArbIdle    = 3'd0,
      ArbIfBusy  = 3'd1,
      ArbMemBusy = 3'd2,
      ArbIfDone  = 3'd3,
      ArbMemDone = 3'd4
   } arb_state_t;

   localparam int unsigned StallIfIdx  = 1;
   localparam int unsigned StallMemIdx = 4;

   localparam logic [3:0] SelFetch = 4'b1111;

   // True while a bus transaction is outstanding.
   function automatic logic is_busy(input arb_state_t s);
      return (s == ArbIfBusy) || (s == ArbMemBusy);
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_arb_watchdog.sv
// Bus watchdog: counts cycles spent waiting for bus_ack and flags expiry
// on the TIMEOUT_CYCLES-th busy cycle without an ack. Only instantiated
// when ARB_TIMEOUT_EN is defined.
module arb_watchdog
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  arb_state_t i_state,
   input  logic       i_ack,
   output logic       o_expired
);

   localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES - 1);

   logic            w_busy;
   logic [CntW-1:0] r_count;

   assign w_busy    = is_busy(i_state);
   assign o_expired = w_busy && !i_ack && (r_count == Limit);

   // Busy-cycle counter; clears on ack, on expiry and whenever not busy.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_count <= '0;
      end else if (!w_busy || i_ack || o_expired) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the IF fetch port and the MEM data port onto one external bus
// with a req/ack handshake. MEM wins same-cycle contests. Returned data is
// held in per-port buffers until the pipeline releases the stalled stage.
// Optional feature macro: ARB_TIMEOUT_EN (bus watchdog with bus_err pulse).
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall,
   input  logic        flush,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_stallreq,
   input  logic        mem_ce,
   input  logic        mem_we,
   input  logic [3:0]  mem_sel,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_stallreq,
   output logic        bus_req,
   output logic        bus_we,
   output logic [3:0]  bus_sel,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   output logic        bus_err
);

   arb_state_t  r_state;
   arb_state_t  w_next;
   logic        r_abort;
   logic        w_abort;
   logic        w_timeout;
   logic        w_finish;
   logic [31:0] w_rdata_in;
   logic        r_bus_req;
   logic        r_bus_we;
   logic [3:0]  r_bus_sel;
   logic [31:0] r_bus_addr;
   logic [31:0] r_bus_wdata;
   logic [31:0] r_if_rdata;
   logic [31:0] r_mem_rdata;
   logic        w_unused_stall;

   assign w_unused_stall = ^{stall[5], stall[3:2], stall[0]};

`ifdef ARB_TIMEOUT_EN
   logic r_bus_err;

   arb_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_state  (r_state),
      .i_ack    (bus_ack),
      .o_expired(w_timeout)
   );

   // One-cycle error pulse registered from the watchdog expiry.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_bus_err <= 1'b0;
      end else begin
         r_bus_err <= w_timeout;
      end
   end

   assign bus_err = r_bus_err;
`else
   logic [31:0] w_unused_timeout;

   assign w_unused_timeout = TIMEOUT_CYCLES;
   assign w_timeout        = 1'b0;
   assign bus_err          = 1'b0;
`endif

   // A flush arriving in the same cycle as the ack still aborts the result.
   assign w_abort    = r_abort || flush;
   assign w_finish   = bus_ack || w_timeout;
   assign w_rdata_in = bus_ack ? bus_rdata : '0;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ArbIdle;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ArbIdle: begin
            if (mem_ce) begin
               w_next = ArbMemBusy;
            end else if (if_req && !flush) begin
               w_next = ArbIfBusy;
            end
         end
         ArbIfBusy: begin
            if (w_finish) begin
               w_next = w_abort ? ArbIdle : ArbIfDone;
            end
         end
         ArbMemBusy: begin
            if (w_finish) begin
               w_next = w_abort ? ArbIdle : ArbMemDone;
            end
         end
         ArbIfDone: begin
            if (!stall[StallIfIdx] || flush) begin
               w_next = ArbIdle;
            end
         end
         ArbMemDone: begin
            if (!stall[StallMemIdx] || flush) begin
               w_next = ArbIdle;
            end
         end
         default: w_next = ArbIdle;
      endcase
   end

   // Bus request registers, abort flag and per-port read buffers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_bus_req   <= 1'b0;
         r_bus_we    <= 1'b0;
         r_bus_sel   <= '0;
         r_bus_addr  <= '0;
         r_bus_wdata <= '0;
         r_if_rdata  <= '0;
         r_mem_rdata <= '0;
         r_abort     <= 1'b0;
      end else begin
         case (r_state)
            ArbIdle: begin
               if (mem_ce) begin
                  r_bus_req   <= 1'b1;
                  r_bus_we    <= mem_we;
                  r_bus_sel   <= mem_sel;
                  r_bus_addr  <= mem_addr;
                  r_bus_wdata <= mem_wdata;
               end else if (if_req && !flush) begin
                  r_bus_req   <= 1'b1;
                  r_bus_we    <= 1'b0;
                  r_bus_sel   <= SelFetch;
                  r_bus_addr  <= if_addr;
                  r_bus_wdata <= '0;
               end
            end
            ArbIfBusy, ArbMemBusy: begin
               if (flush) begin
                  r_abort <= 1'b1;
               end
               if (w_finish) begin
                  r_bus_req <= 1'b0;
                  r_abort   <= 1'b0;
                  if (!w_abort) begin
                     if (r_state == ArbIfBusy) begin
                        r_if_rdata <= w_rdata_in;
                     end else begin
                        r_mem_rdata <= w_rdata_in;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus_req      = r_bus_req;
   assign bus_we       = r_bus_we;
   assign bus_sel      = r_bus_sel;
   assign bus_addr     = r_bus_addr;
   assign bus_wdata    = r_bus_wdata;
   assign if_rdata     = r_if_rdata;
   assign mem_rdata    = r_mem_rdata;
   assign if_stallreq  = if_req && (r_state != ArbIfDone);
   assign mem_stallreq = mem_ce && (r_state != ArbMemDone);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter. Directed stimulus pushes expected
// bus transactions and port completions into queues; a negedge monitor pops
// and compares whenever a new bus request or a port completion appears.
// Build with ARB_TIMEOUT_EN defined to exercise the watchdog path.
module tb_mem_bus_arbiter;

   typedef struct {
      logic        we;
      logic [3:0]  sel;
      logic [31:0] addr;
      logic [31:0] wdata;
   } bus_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic        flush;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_stallreq;
   logic        mem_ce;
   logic        mem_we;
   logic [3:0]  mem_sel;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_stallreq;
   logic        bus_req;
   logic        bus_we;
   logic [3:0]  bus_sel;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ack;
   logic        bus_err;

   int n_checks = 0;
   int n_errors = 0;
   int n_err_pulses = 0;

   bus_t        exp_bus[$];
   logic [31:0] exp_if[$];
   logic [31:0] exp_mem[$];

   logic prev_bus_req  = 1'b0;
   logic prev_if_done  = 1'b0;
   logic prev_mem_done = 1'b0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(
      .TIMEOUT_CYCLES(4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .flush       (flush),
      .if_req      (if_req),
      .if_addr     (if_addr),
      .if_rdata    (if_rdata),
      .if_stallreq (if_stallreq),
      .mem_ce      (mem_ce),
      .mem_we      (mem_we),
      .mem_sel     (mem_sel),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_stallreq(mem_stallreq),
      .bus_req     (bus_req),
      .bus_we      (bus_we),
      .bus_sel     (bus_sel),
      .bus_addr    (bus_addr),
      .bus_wdata   (bus_wdata),
      .bus_rdata   (bus_rdata),
      .bus_ack     (bus_ack),
      .bus_err     (bus_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_bus(input logic we, input logic [3:0] sel,
                           input logic [31:0] addr, input logic [31:0] wdata);
      bus_t t;
      t.we = we; t.sel = sel; t.addr = addr; t.wdata = wdata;
      exp_bus.push_back(t);
   endtask

   // Monitor: new bus transactions and rising port completions.
   always @(negedge clk) begin
      logic if_done;
      logic mem_done;
      bus_t t;
      logic [31:0] e;
      if_done  = (if_req === 1'b1) && (if_stallreq === 1'b0);
      mem_done = (mem_ce === 1'b1) && (mem_stallreq === 1'b0);
      if (bus_err === 1'b1) n_err_pulses++;
      if (bus_req === 1'b1 && !prev_bus_req) begin
         if (exp_bus.size() == 0) begin
            chk("unexpected_bus_txn", bus_addr, 32'h0);
         end else begin
            t = exp_bus.pop_front();
            chk("bus_we",   32'(bus_we),  32'(t.we));
            chk("bus_sel",  32'(bus_sel), 32'(t.sel));
            chk("bus_addr", bus_addr,     t.addr);
            if (t.we) chk("bus_wdata", bus_wdata, t.wdata);
         end
      end
      if (if_done && !prev_if_done) begin
         if (exp_if.size() == 0) begin
            chk("unexpected_if_done", if_rdata, 32'h0);
         end else begin
            e = exp_if.pop_front();
            chk("if_rdata", if_rdata, e);
         end
      end
      if (mem_done && !prev_mem_done) begin
         if (exp_mem.size() == 0) begin
            chk("unexpected_mem_done", mem_rdata, 32'h0);
         end else begin
            e = exp_mem.pop_front();
            chk("mem_rdata", mem_rdata, e);
         end
      end
      prev_bus_req  = (bus_req === 1'b1);
      prev_if_done  = if_done;
      prev_mem_done = mem_done;
   end

   initial begin
      rst = 1'b0; stall = '0; flush = 1'b0;
      if_req = 1'b0; if_addr = '0;
      mem_ce = 1'b0; mem_we = 1'b0; mem_sel = '0; mem_addr = '0; mem_wdata = '0;
      bus_rdata = '0; bus_ack = 1'b0;

      // Reset state
      step(); step();
      @(negedge clk);
      chk("rst_bus_req",   32'(bus_req),   32'h0);
      chk("rst_bus_we",    32'(bus_we),    32'h0);
      chk("rst_bus_sel",   32'(bus_sel),   32'h0);
      chk("rst_bus_addr",  bus_addr,       32'h0);
      chk("rst_bus_wdata", bus_wdata,      32'h0);
      chk("rst_if_rdata",  if_rdata,       32'h0);
      chk("rst_mem_rdata", mem_rdata,      32'h0);
      chk("rst_bus_err",   32'(bus_err),   32'h0);
      step(); rst = 1'b1;
      step();

      // Single fetch, ack one cycle after bus_req
      step();
      if_req = 1'b1; if_addr = 32'hBFC0_0000;
      push_bus(1'b0, 4'hF, 32'hBFC0_0000, 32'h0);
      exp_if.push_back(32'h2401_0001);
      step();
      bus_ack = 1'b1; bus_rdata = 32'h2401_0001;
      @(negedge clk);
      chk("f1_c1_bus_req", 32'(bus_req), 32'h1);
      chk("f1_c1_if_stallreq", 32'(if_stallreq), 32'h1);
      step();
      bus_ack = 1'b0;
      @(negedge clk);
      chk("f1_c2_if_stallreq", 32'(if_stallreq), 32'h0);
      chk("f1_c2_bus_req", 32'(bus_req), 32'h0);
      step(); if_req = 1'b0;
      step();

      // MEM store and fetch together: store first, fetch afterwards
      step();
      mem_ce = 1'b1; mem_we = 1'b1; mem_sel = 4'b0011;
      mem_addr = 32'h8000_0010; mem_wdata = 32'hA5A5_1234;
      if_req = 1'b1; if_addr = 32'hBFC0_0004;
      push_bus(1'b1, 4'b0011, 32'h8000_0010, 32'hA5A5_1234);
      push_bus(1'b0, 4'hF, 32'hBFC0_0004, 32'h0);
      exp_mem.push_back(32'hDEAD_BEEF);
      exp_if.push_back(32'h8C02_0000);
      step();
      bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("c2_c1_if_stallreq", 32'(if_stallreq), 32'h1);
      step();
      bus_ack = 1'b0;
      @(negedge clk);
      chk("c2_c2_mem_stallreq", 32'(mem_stallreq), 32'h0);
      chk("c2_c2_if_stallreq", 32'(if_stallreq), 32'h1);
      step();
      mem_ce = 1'b0; mem_we = 1'b0;
      @(negedge clk);
      chk("c2_c3_fetch_not_yet", 32'(bus_req), 32'h0);
      step();
      bus_ack = 1'b1; bus_rdata = 32'h8C02_0000;
      @(negedge clk);
      chk("c2_c4_fetch_issued", 32'(bus_req), 32'h1);
      step();
      bus_ack = 1'b0;
      @(negedge clk);
      chk("c2_c5_if_stallreq", 32'(if_stallreq), 32'h0);
      step(); if_req = 1'b0;
      step();

      // Load completing while stall[4] holds MEM_DONE for 3 cycles
      step();
      mem_ce = 1'b1; mem_we = 1'b0; mem_sel = 4'hF;
      mem_addr = 32'h8000_0020; mem_wdata = 32'h0;
      push_bus(1'b0, 4'hF, 32'h8000_0020, 32'h0);
      exp_mem.push_back(32'h1122_3344);
      step();
      bus_ack = 1'b1; bus_rdata = 32'h1122_3344; stall = 6'b01_0000;
      step();
      bus_ack = 1'b0; bus_rdata = 32'hFFFF_FFFF;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) stall = '0;
         @(negedge clk);
         chk("ld_hold_mem_stallreq", 32'(mem_stallreq), 32'h0);
         chk("ld_hold_mem_rdata", mem_rdata, 32'h1122_3344);
         step();
      end
      @(negedge clk);
      chk("ld_exit_mem_stallreq", 32'(mem_stallreq), 32'h1);
      #1 mem_ce = 1'b0;
      step();

`ifdef ARB_TIMEOUT_EN
      // Watchdog: no ack for TIMEOUT_CYCLES=4 busy cycles
      step();
      mem_ce = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h8000_0040;
      push_bus(1'b0, 4'hF, 32'h8000_0040, 32'h0);
      exp_mem.push_back(32'h0);
      for (int i = 0; i < 4; i++) begin
         step();
         @(negedge clk);
         chk("to_busy_bus_req", 32'(bus_req), 32'h1);
         chk("to_busy_bus_err", 32'(bus_err), 32'h0);
      end
      step();
      @(negedge clk);
      chk("to_bus_err", 32'(bus_err), 32'h1);
      chk("to_bus_req", 32'(bus_req), 32'h0);
      chk("to_mem_stallreq", 32'(mem_stallreq), 32'h0);
      chk("to_mem_rdata", mem_rdata, 32'h0);
      step();
      mem_ce = 1'b0;
      @(negedge clk);
      chk("to_bus_err_pulse_end", 32'(bus_err), 32'h0);
      step();
`endif

      // Flush during IF_BUSY, ack two cycles later: result discarded
      step();
      if_req = 1'b1; if_addr = 32'hBFC0_0008;
      push_bus(1'b0, 4'hF, 32'hBFC0_0008, 32'h0);
      step();
      flush = 1'b1;
      @(negedge clk);
      chk("fl_c1_bus_req", 32'(bus_req), 32'h1);
      step();
      flush = 1'b0;
      @(negedge clk);
      chk("fl_c2_if_stallreq", 32'(if_stallreq), 32'h1);
      step();
      bus_ack = 1'b1; bus_rdata = 32'h9999_9999;
      @(negedge clk);
      chk("fl_c3_bus_req", 32'(bus_req), 32'h1);
      step();
      bus_ack = 1'b0; if_addr = 32'hBFC0_000C;
      push_bus(1'b0, 4'hF, 32'hBFC0_000C, 32'h0);
      exp_if.push_back(32'h3C1D_BFC0);
      @(negedge clk);
      chk("fl_c4_bus_req", 32'(bus_req), 32'h0);
      chk("fl_c4_no_done", 32'(if_stallreq), 32'h1);
      chk("fl_c4_if_rdata_kept", if_rdata, 32'h8C02_0000);
      step();
      bus_ack = 1'b1; bus_rdata = 32'h3C1D_BFC0;
      @(negedge clk);
      chk("fl_c5_refetch_req", 32'(bus_req), 32'h1);
      step();
      bus_ack = 1'b0;
      @(negedge clk);
      chk("fl_c6_if_stallreq", 32'(if_stallreq), 32'h0);
      step(); if_req = 1'b0;
      step();

      // Stray ack while idle is ignored
      step();
      bus_ack = 1'b1; bus_rdata = 32'h5555_5555;
      @(negedge clk);
      chk("ign_bus_req", 32'(bus_req), 32'h0);
      step();
      bus_ack = 1'b0;
      @(negedge clk);
      chk("ign_if_rdata", if_rdata, 32'h3C1D_BFC0);
`ifdef ARB_TIMEOUT_EN
      chk("ign_mem_rdata", mem_rdata, 32'h0);
`else
      chk("ign_mem_rdata", mem_rdata, 32'h1122_3344);
`endif

      // Reset during MEM_BUSY abandons the transaction
      step();
      mem_ce = 1'b1; mem_we = 1'b1; mem_sel = 4'b1100;
      mem_addr = 32'h8000_0030; mem_wdata = 32'hCAFE_F00D;
      push_bus(1'b1, 4'b1100, 32'h8000_0030, 32'hCAFE_F00D);
      step();
      rst = 1'b0; if_req = 1'b1;
      @(negedge clk);
      chk("mr_c1_bus_req", 32'(bus_req), 32'h1);
      step();
      @(negedge clk);
      chk("mr_bus_req",   32'(bus_req), 32'h0);
      chk("mr_bus_we",    32'(bus_we),  32'h0);
      chk("mr_bus_sel",   32'(bus_sel), 32'h0);
      chk("mr_bus_addr",  bus_addr,     32'h0);
      chk("mr_bus_wdata", bus_wdata,    32'h0);
      chk("mr_if_rdata",  if_rdata,     32'h0);
      chk("mr_mem_rdata", mem_rdata,    32'h0);
      chk("mr_bus_err",   32'(bus_err), 32'h0);
      chk("mr_mem_stallreq_follows", 32'(mem_stallreq), 32'h1);
      chk("mr_if_stallreq_follows",  32'(if_stallreq),  32'h1);
      #1;
      mem_ce = 1'b0; mem_we = 1'b0; if_req = 1'b0;
      step();
      rst = 1'b1;
      step();
      @(negedge clk);
      chk("mr_after_bus_req", 32'(bus_req), 32'h0);
      step();

      // Drain checks
`ifdef ARB_TIMEOUT_EN
      chk("err_pulse_count", n_err_pulses, 32'd1);
`else
      chk("err_pulse_count", n_err_pulses, 32'd0);
`endif
      chk("bus_queue_left", exp_bus.size(), 32'd0);
      chk("if_queue_left",  exp_if.size(),  32'd0);
      chk("mem_queue_left", exp_mem.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
